// File: rtl/abqm_teller_dispatch.sv
// Teller-side dispatcher for the ABQM queue: issues BCD tickets, tracks occupancy,
// and hands waiting customers to on-duty tellers in round-robin order.
module abqm_teller_dispatch #(
  parameter int NUM_TELLERS = 3,
  parameter int QDEPTH      = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arrive,
  input  logic [NUM_TELLERS-1:0] teller_en,
  input  logic [NUM_TELLERS-1:0] teller_req,
  output logic                   issue_valid,
  output logic [7:0]             issue_ticket,
  output logic                   reject,
  output logic                   call_valid,
  output logic [1:0]             call_teller,
  output logic [7:0]             call_ticket,
  output logic [2:0]             pcount,
  output logic [1:0]             tcount,
  output logic                   full,
  output logic                   empty
);

  localparam logic [2:0] QMAX    = 3'(QDEPTH);
  localparam logic [2:0] NT      = 3'(NUM_TELLERS);
  localparam logic [1:0] LAST_TL = 2'(NUM_TELLERS - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  function automatic logic [1:0] popcount_sat(input logic [NUM_TELLERS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_TELLERS; i++) n = n + 3'(v[i]);
    return (n > 3'd3) ? 2'd3 : n[1:0];
  endfunction

  logic [7:0]               next_ticket;
  logic [7:0]               head_ticket;
  logic [1:0]               rr_ptr;
  logic [NUM_TELLERS-1:0]   elig;
  logic [2*NUM_TELLERS-1:0] rot2;
  logic [2:0]               sum;
  logic                     grant_found;
  logic [1:0]               grant_idx;
  logic                     call_go;
  logic                     issue_go;
  logic [2:0]               pcount_nxt;

  // Decision stage: arbitration and occupancy update from the sampled inputs
  always_comb begin
    elig        = teller_req & teller_en;
    rot2        = {elig, elig} >> rr_ptr;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = 0; i < NUM_TELLERS; i++) begin
      if (!grant_found && rot2[i]) begin
        grant_found = 1'b1;
        sum         = 3'(rr_ptr) + 3'(i);
        if (sum >= NT) sum = sum - NT;
        grant_idx   = sum[1:0];
      end
    end
    call_go  = grant_found && (pcount != 3'd0);
    // A same-edge call frees a slot, so a full queue can still accept an arrival
    issue_go = arrive && ((pcount != QMAX) || call_go);
    case ({issue_go, call_go})
      2'b10:   pcount_nxt = pcount + 3'd1;
      2'b01:   pcount_nxt = pcount - 3'd1;
      default: pcount_nxt = pcount;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid  <= 1'b0;
      issue_ticket <= '0;
      reject       <= 1'b0;
      call_valid   <= 1'b0;
      call_teller  <= '0;
      call_ticket  <= '0;
      pcount       <= '0;
      tcount       <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      next_ticket  <= '0;
      head_ticket  <= '0;
      rr_ptr       <= '0;
    end else begin
      issue_valid <= issue_go;
      reject      <= arrive && !issue_go;
      call_valid  <= call_go;
      if (issue_go) begin
        issue_ticket <= next_ticket;
        next_ticket  <= bcd_inc(next_ticket);
      end
      if (call_go) begin
        call_teller <= grant_idx;
        call_ticket <= head_ticket;
        head_ticket <= bcd_inc(head_ticket);
        rr_ptr      <= (grant_idx == LAST_TL) ? 2'd0 : grant_idx + 2'd1;
      end
      pcount <= pcount_nxt;
      full   <= (pcount_nxt == QMAX);
      empty  <= (pcount_nxt == 3'd0);
      tcount <= popcount_sat(teller_en);
    end
  end

endmodule

// File: tb/tb_abqm_teller_dispatch.sv
// Directed bench for abqm_teller_dispatch: expected issues and calls are queued
// per edge and matched against the DUT pulses after that edge.
module tb_abqm_teller_dispatch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arrive = 1'b0;
  logic [2:0] teller_en = '0;
  logic [2:0] teller_req = '0;
  logic       issue_valid;
  logic [7:0] issue_ticket;
  logic       reject;
  logic       call_valid;
  logic [1:0] call_teller;
  logic [7:0] call_ticket;
  logic [2:0] pcount;
  logic [1:0] tcount;
  logic       full;
  logic       empty;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_issue[$];
  logic [9:0] exp_call[$];

  abqm_teller_dispatch #(.NUM_TELLERS(3), .QDEPTH(7)) dut (
    .clk(clk), .reset(reset), .arrive(arrive),
    .teller_en(teller_en), .teller_req(teller_req),
    .issue_valid(issue_valid), .issue_ticket(issue_ticket), .reject(reject),
    .call_valid(call_valid), .call_teller(call_teller), .call_ticket(call_ticket),
    .pcount(pcount), .tcount(tcount), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock edge, then compare pulses against whatever was queued for this edge
  task automatic tick();
    logic [7:0] ei;
    logic [9:0] ec;
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(exp_issue.size() != 0));
    if (issue_valid && exp_issue.size() != 0) begin
      ei = exp_issue.pop_front();
      chk("issue_ticket", 32'(issue_ticket), 32'(ei));
    end
    exp_issue.delete();
    chk("call_valid", 32'(call_valid), 32'(exp_call.size() != 0));
    if (call_valid && exp_call.size() != 0) begin
      ec = exp_call.pop_front();
      chk("call_teller_ticket", 32'({call_teller, call_ticket}), 32'(ec));
    end
    exp_call.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_issue_valid"},  32'(issue_valid),  32'd0);
    chk({tag, "_issue_ticket"}, 32'(issue_ticket), 32'd0);
    chk({tag, "_reject"},       32'(reject),       32'd0);
    chk({tag, "_call_valid"},   32'(call_valid),   32'd0);
    chk({tag, "_call_teller"},  32'(call_teller),  32'd0);
    chk({tag, "_call_ticket"},  32'(call_ticket),  32'd0);
    chk({tag, "_pcount"},       32'(pcount),       32'd0);
    chk({tag, "_tcount"},       32'(tcount),       32'd0);
    chk({tag, "_full"},         32'(full),         32'd0);
    chk({tag, "_empty"},        32'(empty),        32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_issue.delete();
    exp_call.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk_reset_state("rst");
    reset = 1'b0;

    // Three arrivals issue 00,01,02
    arrive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_issue.push_back(bcd(i));
      tick();
    end
    arrive = 1'b0;
    chk("t1_pcount", 32'(pcount), 32'd3);
    chk("t1_empty", 32'(empty), 32'd0);

    // All tellers requesting: round-robin 0,1,2 drains the queue
    teller_en = 3'b111;
    teller_req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      exp_call.push_back({2'(i), bcd(i)});
      tick();
      if (i == 0) chk("t3_tcount", 32'(tcount), 32'd3);
    end
    teller_req = 3'b000;
    chk("t3_pcount", 32'(pcount), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);

    // Request while empty stays pending until a customer arrives
    apply_reset();
    teller_req = 3'b010;
    tick();
    tick();
    arrive = 1'b1;
    exp_issue.push_back(bcd(0));
    tick();
    arrive = 1'b0;
    exp_call.push_back({2'd1, bcd(0)});
    tick();
    teller_req = 3'b000;
    chk("t4_pcount", 32'(pcount), 32'd0);

    // Fill with no tellers; eighth arrival is rejected
    teller_en = 3'b000;
    apply_reset();
    arrive = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) exp_issue.push_back(bcd(i));
      tick();
      chk("t2_reject", 32'(reject), 32'(i == 7));
    end
    arrive = 1'b0;
    chk("t2_pcount", 32'(pcount), 32'd7);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_tcount", 32'(tcount), 32'd0);
    tick();
    chk("t2_reject_clear", 32'(reject), 32'd0);

    // Full queue: simultaneous arrival and call both proceed
    teller_en = 3'b001;
    teller_req = 3'b001;
    arrive = 1'b1;
    exp_issue.push_back(bcd(7));
    exp_call.push_back({2'd0, bcd(0)});
    tick();
    chk("t5_reject", 32'(reject), 32'd0);
    chk("t5_pcount", 32'(pcount), 32'd7);
    chk("t5_full", 32'(full), 32'd1);
    arrive = 1'b0;
    teller_req = 3'b000;
    tick();
    chk("t5_pcount_hold", 32'(pcount), 32'd7);

    // 135 issue/call pairs wrap the BCD ticket through 99 -> 00
    teller_en = 3'b001;
    apply_reset();
    arrive = 1'b1;
    teller_req = 3'b001;
    for (int k = 0; k < 135; k++) begin
      exp_issue.push_back(bcd(k % 100));
      if (k > 0) exp_call.push_back({2'd0, bcd((k - 1) % 100)});
      tick();
      if (k > 0) chk("t6_pcount", 32'(pcount), 32'd1);
    end

    // Asynchronous reset mid-run, away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    exp_issue.delete();
    exp_call.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    teller_req = 3'b000;
    exp_issue.push_back(bcd(0));
    tick();
    arrive = 1'b0;
    chk("t6_post_pcount", 32'(pcount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
